// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter: loads a WIDTH-bit word, streams it one bit per accepted cycle.
// Optional BIT_SERIALIZER_ZERO_SKIP_EN ends a word early once the remaining bits are all zero.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         din,
  output logic                     ser_out,
  output logic                     ser_valid,
  input  logic                     ser_ready,
  output logic [$clog2(WIDTH)-1:0] bit_idx,
  output logic                     last,
  output logic                     done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             head_bit;
  logic             is_last;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    head_bit = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
`ifdef BIT_SERIALIZER_ZERO_SKIP_EN
    // Bits still queued behind the head; once they are all zero this bit ends the word.
    if (MSB_FIRST) is_last = (sreg_q[WIDTH-2:0] == '0);
    else           is_last = (sreg_q[WIDTH-1:1] == '0);
`else
    is_last = (cnt_q == CW'(WIDTH - 1));
`endif
  end

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    ser_valid = 1'b0;
    ser_out   = 1'b0;
    bit_idx   = '0;
    last      = 1'b0;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        // Reset is gated in so a held reset never advertises readiness.
        in_ready = ~Rst;
        if (in_valid) begin
          sreg_d  = din;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef BIT_SERIALIZER_ZERO_SKIP_EN
          if (din == '0) state_d = DONE;
`endif
        end
      end

      SHIFT: begin
        ser_valid = 1'b1;
        ser_out   = head_bit;
        bit_idx   = MSB_FIRST ? (CW'(WIDTH - 1) - cnt_q) : cnt_q;
        last      = is_last;
        if (ser_ready) begin
          if (MSB_FIRST) sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
          else           sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
          cnt_d = cnt_q + 1'b1;
          if (is_last) begin
            cnt_d   = '0;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
